pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage_pkg.sv | 26 ++
 rtl/Mux2to1_32bit.sv | 13 +
 rtl/pc_fetch_stage.sv | 111 +++++++++++
 tb/tb_pc_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the PC fetch stage: reset/increment defaults,
// FSM state encoding, decode-register payload and an alignment helper.
package pc_fetch_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INCR  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_DEC = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
  } dec_payload_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/Mux2to1_32bit.sv
// 2:1 32-bit selector used on the PC-update path.
module Mux2to1_32bit
  import pc_fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] Input0,
  input  logic [XLEN-1:0] Input1,
  input  logic            Sel,
  output logic [XLEN-1:0] Result
);

  assign Result = Sel ? Input1 : Input0;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: walks the PC, issues one memory read at a time
// and parks the returned word in a decode register until decode takes it.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = pc_fetch_stage_pkg::RESET_PC,
  parameter int unsigned PC_INCR  = pc_fetch_stage_pkg::PC_INCR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC_Next,
  input  logic        PC_Load,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic        Dec_Valid,
  input  logic        Dec_Ready,
  output logic [31:0] Dec_Instr,
  output logic [31:0] Dec_PC,
  output logic [31:0] Dec_PCPlus4,
  output logic        Misalign_Err
);

  import pc_fetch_stage_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  dec_payload_t dec_q, dec_d;
  logic         dec_valid_q, dec_valid_d;
  logic         req_q, req_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  pc_plus_incr;
  logic [31:0]  pc_aligned;
  logic [31:0]  pc_mux;
  logic         redirect;

  assign pc_plus_incr = pc_q + 32'(PC_INCR);
  assign pc_aligned   = align_word(PC_Next);
  assign redirect     = PC_Load && (state_q != IDLE);

  Mux2to1_32bit u_pc_mux (
    .Input0 (pc_plus_incr),
    .Input1 (pc_aligned),
    .Sel    (PC_Load),
    .Result (pc_mux)
  );

  // Next-state: a redirect outranks ack and decode handshake in any active state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    misalign_d  = misalign_q;

    if (redirect) begin
      pc_d        = pc_mux;
      dec_valid_d = 1'b0;
      state_d     = FETCH;
      if (PC_Next[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (Imem_Ack) begin
            dec_d       = '{instr: Imem_Data, pc: pc_q, pc_plus: pc_plus_incr};
            dec_valid_d = 1'b1;
            pc_d        = pc_mux;
            state_d     = WAIT_DEC;
          end
        end
        WAIT_DEC: begin
          if (dec_valid_q && Dec_Ready) begin
            dec_valid_d = 1'b0;
            state_d     = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_d = (state_d == FETCH);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      req_q       <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      req_q       <= req_d;
      misalign_q  <= misalign_d;
    end
  end

  assign Imem_Req     = req_q;
  assign Imem_Addr    = pc_q;
  assign Dec_Valid    = dec_valid_q;
  assign Dec_Instr    = dec_q.instr;
  assign Dec_PC       = dec_q.pc;
  assign Dec_PCPlus4  = dec_q.pc_plus;
  assign Misalign_Err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus random traffic, all
// compared against a transaction-level model of the fetch/decode handoff.
module tb_pc_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pcplus4;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  // Model: "waiting for decode" is just whether a word is held; otherwise fetching.
  bit          m_idle;
  bit          m_held;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_dpc;
  logic [31:0] m_dpc4;

  pc_fetch_stage dut (
    .Clk          (clk),
    .Reset        (reset),
    .PC_Next      (pc_next),
    .PC_Load      (pc_load),
    .Imem_Req     (imem_req),
    .Imem_Addr    (imem_addr),
    .Imem_Ack     (imem_ack),
    .Imem_Data    (imem_data),
    .Dec_Valid    (dec_valid),
    .Dec_Ready    (dec_ready),
    .Dec_Instr    (dec_instr),
    .Dec_PC       (dec_pc),
    .Dec_PCPlus4  (dec_pcplus4),
    .Misalign_Err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_held  = 1'b0;
    m_mis   = 1'b0;
    m_pc    = 32'h0000_0000;
    m_instr = '0;
    m_dpc   = '0;
    m_dpc4  = '0;
  endtask

  task automatic model_cycle(input bit ld, input logic [31:0] nx, input bit ak,
                             input logic [31:0] dt, input bit rd);
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (ld) begin
      m_pc   = (nx / 4) * 4;
      m_held = 1'b0;
      if (nx % 4 != 0) m_mis = 1'b1;
    end else if (!m_held && ak) begin
      m_instr = dt;
      m_dpc   = m_pc;
      m_dpc4  = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_held  = 1'b1;
    end else if (m_held && rd) begin
      m_held = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("imem_req",  32'(imem_req),     32'(!m_idle && !m_held));
    check_eq("imem_addr", imem_addr,         m_pc);
    check_eq("dec_valid", 32'(dec_valid),    32'(m_held));
    check_eq("dec_instr", dec_instr,         m_instr);
    check_eq("dec_pc",    dec_pc,            m_dpc);
    check_eq("dec_pc4",   dec_pcplus4,       m_dpc4);
    check_eq("misalign",  32'(misalign_err), 32'(m_mis));
  endtask

  // Apply one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input bit ld, input logic [31:0] nx, input bit ak,
                      input logic [31:0] dt, input bit rd);
    pc_load   = ld;
    pc_next   = nx;
    imem_ack  = ak;
    imem_data = dt;
    dec_ready = rd;
    @(posedge clk);
    #1;
    model_cycle(ld, nx, ak, dt, rd);
    check_all();
  endtask

  task automatic random_traffic(input int n, input bit aligned_only);
    for (int i = 0; i < n; i++) begin
      logic [31:0] nx;
      nx = $urandom;
      if ($urandom_range(3) == 0) nx = 32'hFFFF_FFF0 | (nx & 32'hF);
      if (aligned_only) nx = nx & 32'hFFFF_FFFC;
      step($urandom_range(7) == 0, nx, 1'($urandom_range(1)), $urandom,
           1'($urandom_range(1)));
    end
  endtask

  initial begin
    pc_load   = 1'b0;
    pc_next   = '0;
    imem_ack  = 1'b0;
    imem_data = '0;
    dec_ready = 1'b0;
    reset     = 1'b1;
    model_reset();
    #2;
    check_all();

    // Reset ignores the clock and load requests.
    pc_load = 1'b1;
    pc_next = 32'h0000_0101;
    @(posedge clk);
    #1;
    check_all();
    pc_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // PC_Load during IDLE is ignored.
    step(1'b1, 32'h0000_0203, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_eq("idle_load_ignored", imem_addr, 32'h0);

    // Basic fetch, capture and handoff.
    step(1'b0, 32'h0, 1'b1, 32'h2008_0005, 1'b1);
    check_eq("first_instr", dec_instr,   32'h2008_0005);
    check_eq("first_pc",    dec_pc,      32'h0);
    check_eq("first_pc4",   dec_pcplus4, 32'h4);
    check_eq("next_addr",   imem_addr,   32'h4);

    // Decode stall: acks during the stall must be ignored.
    for (int i = 0; i < 5; i++)
      step(1'b0, 32'h0, 1'($urandom_range(1)), $urandom, 1'b0);
    check_eq("stall_instr", dec_instr, 32'h2008_0005);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("resume_req",  32'(imem_req), 32'd1);
    check_eq("resume_addr", imem_addr,     32'h4);

    // Redirect beats a same-cycle ack.
    step(1'b1, 32'h0000_0040, 1'b1, 32'h1234_5678, 1'b1);
    check_eq("redir_valid", 32'(dec_valid), 32'd0);
    check_eq("redir_addr",  imem_addr,      32'h40);

    // Misaligned redirect.
    step(1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0);
    check_eq("mis_addr", imem_addr,         32'h100);
    check_eq("mis_flag", 32'(misalign_err), 32'd1);

    // Wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0);
    check_eq("wrap_pc4",  dec_pcplus4, 32'h0);
    check_eq("wrap_addr", imem_addr,   32'h0);

    // Redirect out of WAIT_DEC, ignoring Dec_Ready.
    step(1'b1, 32'h0000_0800, 1'b0, 32'h0, 1'b1);
    check_eq("wd_redir_addr", imem_addr, 32'h800);

    random_traffic(400, 1'b0);

    // Reset between edges while a fetch is outstanding.
    for (int i = 0; i < 4 && !(imem_req === 1'b1); i++)
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("reach_fetch", 32'(imem_req), 32'd1);
    imem_ack  = 1'b1;
    imem_data = 32'hBAD0_BAD0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_req",  32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr,     32'h0);
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    random_traffic(200, 1'b1);
    check_eq("mis_clear", 32'(misalign_err), 32'd0);
    step(1'b1, 32'h0000_0022, 1'b0, 32'h0, 1'b0);
    random_traffic(100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
